datapath_controller: RTL and testbench

- Multicycle sequencer for the 16-register datapath: fetches 16-bit instructions, decodes them and drives DR/SA/SB/FS/MB/MD/RW/MP/PC.
- Handles branches using the datapath Z flag and jumps using the datapath A-bus output.
- Runs load/store handshakes with data memory, where the address comes from the datapath A bus and the data from its B-mux output.
- Sits beside the datapath in the CPU top level.

---
 rtl/datapath_controller_pkg.sv | 45 ++++
 rtl/datapath_controller_decode.sv | 83 ++++++++
 rtl/datapath_controller.sv | 134 +++++++++++++
 tb/tb_datapath_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, FSM states,
// ALU function codes, next-pc selects and the decoded control bundle.
package datapath_controller_pkg;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_PASSA_C = 4'h0;
  localparam logic [3:0] FS_ADD_C   = 4'h2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_BR   = 3'd2,
    PC_JAL  = 3'd3,
    PC_JR   = 3'd4
  } pc_sel_e;

  typedef struct packed {
    logic [3:0] fs;
    logic       mb;
    logic       md;
    logic       rw;
    logic       mp;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/datapath_controller_decode.sv
// Combinational decode: state + opcode + flags -> control bundle and
// next-pc select. Holds no state of its own.
module datapath_controller_decode
  import datapath_controller_pkg::*;
#(
  parameter logic [3:0] FS_ADD   = FS_ADD_C,
  parameter logic [3:0] FS_PASSA = FS_PASSA_C
) (
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       z_i,
  input  logic       started_i,
  input  logic       dmem_ack_i,
  output ctrl_t      ctrl_o,
  output pc_sel_e    pc_sel_o
);

  // Per-state, per-opcode control generation; everything defaults to 0.
  always_comb begin
    ctrl_o   = '0;
    pc_sel_o = PC_HOLD;
    unique case (state_i)
      FETCH: begin
        // No request until the first clock after reset has been seen.
        ctrl_o.imem_req = started_i;
      end
      EXEC: begin
        if (!op_i[3]) begin
          ctrl_o.fs = {1'b0, op_i[2:0]};
          ctrl_o.rw = 1'b1;
          pc_sel_o  = PC_INC;
        end else begin
          case (op_i)
            OP_ADDI: begin
              ctrl_o.fs = FS_ADD;
              ctrl_o.mb = 1'b1;
              ctrl_o.rw = 1'b1;
              pc_sel_o  = PC_INC;
            end
            OP_BZ: begin
              ctrl_o.fs = FS_PASSA;
              pc_sel_o  = z_i ? PC_BR : PC_INC;
            end
            OP_JAL: begin
              ctrl_o.mp = 1'b1;
              ctrl_o.rw = 1'b1;
              pc_sel_o  = PC_JAL;
            end
            OP_JR: begin
              pc_sel_o = PC_JR;
            end
            OP_RSVD: begin
              ctrl_o.illegal = 1'b1;
              pc_sel_o       = PC_INC;
            end
            default: begin
              // LD, ST and HALT leave pc alone in EXEC.
              pc_sel_o = PC_HOLD;
            end
          endcase
        end
      end
      MEM: begin
        ctrl_o.dmem_req = 1'b1;
        ctrl_o.dmem_we  = (op_i == OP_ST);
        if (dmem_ack_i) begin
          pc_sel_o = PC_INC;
          if (op_i == OP_LD) begin
            ctrl_o.rw = 1'b1;
            ctrl_o.md = 1'b1;
          end
        end
      end
      HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Multicycle sequencer for the 16-register datapath: FSM, IR and pc
// registers; control decode is delegated to datapath_controller_decode.
module datapath_controller
  import datapath_controller_pkg::*;
#(
  parameter int unsigned         PC_W     = 6,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter logic [3:0]          FS_ADD   = FS_ADD_C,
  parameter logic [3:0]          FS_PASSA = FS_PASSA_C
) (
  input  logic            clk_main,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            z_in,
  input  logic [15:0]     a_in,
  output logic [3:0]      DR,
  output logic [3:0]      SA,
  output logic [3:0]      SB,
  output logic [3:0]      FS,
  output logic            MB,
  output logic            MD,
  output logic            RW,
  output logic            MP,
  output logic [PC_W-1:0] PC,
  output logic            halted,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic            started_q;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc_q, pc_d;
  ctrl_t           ctrl;
  pc_sel_e         pc_sel;
  logic [3:0]      op;
  logic            fetch_ack;
  logic [15:0]     br_off;
  logic [15:0]     jal_tgt;
  logic            unused_a;

  assign op        = ir_q[15:12];
  assign fetch_ack = (state_q == FETCH) && started_q && imem_ack;
  assign br_off    = {{8{ir_q[11]}}, ir_q[11:8], ir_q[3:0]};
  assign jal_tgt   = {8'h00, ir_q[7:0]};
  assign unused_a  = ^a_in;

  datapath_controller_decode #(
    .FS_ADD   (FS_ADD),
    .FS_PASSA (FS_PASSA)
  ) u_decode (
    .state_i    (state_q),
    .op_i       (op),
    .z_i        (z_in),
    .started_i  (started_q),
    .dmem_ack_i (dmem_ack),
    .ctrl_o     (ctrl),
    .pc_sel_o   (pc_sel)
  );

  // State, IR and pc registers; reset aborts any pending access at once.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      ir_q      <= '0;
      pc_q      <= RESET_PC;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      pc_q      <= pc_d;
      if (fetch_ack) begin
        ir_q <= imem_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (fetch_ack) state_d = EXEC;
      EXEC: begin
        if (op == OP_LD || op == OP_ST) begin
          state_d = MEM;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      MEM:     if (dmem_ack) state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Next-pc selection; all arithmetic wraps modulo 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_INC:  pc_d = pc_q + PC_W'(1);
      PC_BR:   pc_d = pc_q + br_off[PC_W-1:0];
      PC_JAL:  pc_d = jal_tgt[PC_W-1:0];
      PC_JR:   pc_d = a_in[PC_W-1:0];
      default: pc_d = pc_q;
    endcase
  end

  // Output mapping from the decoded bundle and IR fields.
  always_comb begin
    imem_req  = ctrl.imem_req;
    imem_addr = pc_q;
    dmem_req  = ctrl.dmem_req;
    dmem_we   = ctrl.dmem_we;
    DR        = ir_q[11:8];
    SA        = ir_q[7:4];
    SB        = ir_q[3:0];
    FS        = ctrl.fs;
    MB        = ctrl.mb;
    MD        = ctrl.md;
    RW        = ctrl.rw;
    MP        = ctrl.mp;
    PC        = pc_q;
    halted    = ctrl.halted;
    illegal   = ctrl.illegal;
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller with hand-computed expectations.
module tb_datapath_controller;

  logic        clk_main;
  logic        reset;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        z_in;
  logic [15:0] a_in;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MD, RW, MP;
  logic [5:0]  PC;
  logic        halted;
  logic        illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;

  datapath_controller #(
    .PC_W     (6),
    .RESET_PC (6'd0),
    .FS_ADD   (4'h2),
    .FS_PASSA (4'h0)
  ) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .z_in      (z_in),
    .a_in      (a_in),
    .DR        (DR),
    .SA        (SA),
    .SB        (SB),
    .FS        (FS),
    .MB        (MB),
    .MD        (MD),
    .RW        (RW),
    .MP        (MP),
    .PC        (PC),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_main);
  endtask

  // Serve one instruction fetch; returns at the negedge inside EXEC.
  task automatic fetch(input logic [15:0] instr, input int unsigned wait_n);
    int unsigned n;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check_eq("imem_req_up", imem_req, 1);
    for (int unsigned w = 0; w < wait_n; w++) begin
      dmem_ack = 1'b1;
      check_eq("fetch_wait_req", imem_req, 1);
      check_eq("fetch_wait_dreq", dmem_req, 0);
      step();
      dmem_ack = 1'b0;
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
    check_eq("exec_imem_req", imem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = '0;
    dmem_ack  = 1'b0;
    z_in      = 1'b0;
    a_in      = '0;

    // Reset
    repeat (3) @(posedge clk_main);
    step();
    check_eq("rst_pc", PC, 0);
    check_eq("rst_rw", RW, 0);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_halted", halted, 0);
    reset = 1'b1;
    step();
    check_eq("post_rst_imem_req", imem_req, 1);
    check_eq("post_rst_pc", PC, 0);
    check_eq("post_rst_addr", imem_addr, 0);

    // ADDI 0x8123
    fetch(16'h8123, 0);
    check_eq("addi_fs", FS, 4'h2);
    check_eq("addi_mb", MB, 1);
    check_eq("addi_rw", RW, 1);
    check_eq("addi_dr", DR, 1);
    check_eq("addi_sa", SA, 2);
    check_eq("addi_sb", SB, 3);
    check_eq("addi_pc_exec", PC, 0);
    step();
    check_eq("addi_rw_off", RW, 0);
    check_eq("addi_pc", PC, 1);
    check_eq("addi_next_req", imem_req, 1);

    // LD 0x9450 with 3-cycle delayed ack
    fetch(16'h9450, 0);
    check_eq("ld_exec_rw", RW, 0);
    check_eq("ld_exec_dreq", dmem_req, 0);
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      check_eq("ld_dreq", dmem_req, 1);
      check_eq("ld_we", dmem_we, 0);
      check_eq("ld_mb", MB, 0);
      check_eq("ld_ireq", imem_req, 0);
      if (i < 3) begin
        check_eq("ld_wait_rw", RW, 0);
        check_eq("ld_wait_md", MD, 0);
        check_eq("ld_wait_pc", PC, 1);
        step();
      end else begin
        dmem_ack = 1'b1;
        #1;
        check_eq("ld_ack_rw", RW, 1);
        check_eq("ld_ack_md", MD, 1);
        step();
        dmem_ack = 1'b0;
      end
    end
    check_eq("ld_pc", PC, 2);
    check_eq("ld_done_dreq", dmem_req, 0);
    check_eq("ld_done_rw", RW, 0);

    // ST 0xA012 after a delayed fetch with stray dmem acks
    fetch(16'hA012, 2);
    check_eq("st_exec_pc", PC, 2);
    step();
    check_eq("st_dreq", dmem_req, 1);
    check_eq("st_we", dmem_we, 1);
    dmem_ack = 1'b1;
    #1;
    check_eq("st_ack_rw", RW, 0);
    check_eq("st_ack_mb", MB, 0);
    step();
    dmem_ack = 1'b0;
    check_eq("st_pc", PC, 3);

    // Two NOPs to reach PC=5
    fetch(16'h0000, 0);
    step();
    fetch(16'h0000, 0);
    step();
    check_eq("nop_pc", PC, 5);

    // BZ taken
    z_in = 1'b1;
    fetch(16'hBF2E, 0);
    check_eq("bz_t_fs", FS, 4'h0);
    check_eq("bz_t_mb", MB, 0);
    check_eq("bz_t_rw", RW, 0);
    step();
    z_in = 1'b0;
    check_eq("bz_t_pc", PC, 3);

    // JAL back to 5, then BZ not taken
    fetch(16'hC005, 0);
    check_eq("jal5_mp", MP, 1);
    check_eq("jal5_rw", RW, 1);
    step();
    check_eq("jal5_pc", PC, 5);
    fetch(16'hBF2E, 0);
    check_eq("bz_nt_rw", RW, 0);
    step();
    check_eq("bz_nt_pc", PC, 6);

    // JAL to 63 twice, NOP wrap, JR
    fetch(16'hC33F, 0);
    check_eq("jal_mp", MP, 1);
    check_eq("jal_rw", RW, 1);
    check_eq("jal_dr", DR, 3);
    check_eq("jal_pc_held", PC, 6);
    step();
    check_eq("jal_pc", PC, 63);
    fetch(16'hC33F, 0);
    check_eq("jal63_pc_held", PC, 63);
    check_eq("jal63_mp", MP, 1);
    step();
    check_eq("jal63_pc", PC, 63);
    check_eq("jal63_rw_off", RW, 0);
    fetch(16'h0000, 0);
    step();
    check_eq("wrap_pc", PC, 0);
    a_in = 16'h0011;
    fetch(16'hD000, 0);
    check_eq("jr_rw", RW, 0);
    step();
    a_in = '0;
    check_eq("jr_pc", PC, 17);

    // Reserved opcode
    fetch(16'hE000, 0);
    check_eq("rsvd_illegal", illegal, 1);
    check_eq("rsvd_rw", RW, 0);
    step();
    check_eq("rsvd_illegal_off", illegal, 0);
    check_eq("rsvd_pc", PC, 18);

    // Reset mid-MEM
    fetch(16'h9000, 0);
    step();
    check_eq("abort_dreq_before", dmem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_dreq", dmem_req, 0);
    check_eq("abort_pc", PC, 0);
    check_eq("abort_rw", RW, 0);
    check_eq("abort_ireq", imem_req, 0);
    step();
    reset = 1'b1;
    step();
    check_eq("abort_restart_req", imem_req, 1);

    // HALT
    fetch(16'hF000, 0);
    step();
    for (int unsigned i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      check_eq("halt_halted", halted, 1);
      check_eq("halt_ireq", imem_req, 0);
      check_eq("halt_rw", RW, 0);
      step();
    end
    imem_ack = 1'b0;
    check_eq("halt_pc", PC, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
